// File: rtl/cursor_pkg.sv
// Shared definitions for the cursor renderer: FSM states, PS/2 button bit
// positions and the default cursor/pen colours.
package cursor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_RESTORE,
    ST_READ,
    ST_WAIT,
    ST_SAVE,
    ST_PAINT
  } state_t;

  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_MIDDLE = 2;

  localparam logic [11:0] CURSOR_COLOR_DEF = 12'h004;
  localparam logic [11:0] DRAW_COLOR_DEF   = 12'hFFF;

endpackage

// File: rtl/cursor_addr_gen.sv
// Combinational (x, y) -> (bank, address) mapping for the banked panel RAM.
// Rows are split evenly across banks; row stride is H_RES, so the multiply is a shift.
module cursor_addr_gen #(
  parameter int H_RES  = 64,
  parameter int V_RES  = 64,
  parameter int BANKS  = 2,
  parameter int ADDR_W = 12,
  parameter int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  output logic [BANK_W-1:0] bank,
  output logic [ADDR_W-1:0] addr
);

  localparam int ROWS_PER_BANK = V_RES / BANKS;
  localparam int ROW_SHIFT     = $clog2(H_RES);

  logic [7:0] row_in_bank;

  assign row_in_bank = 8'(y % 8'(ROWS_PER_BANK));
  assign bank        = BANK_W'(y / 8'(ROWS_PER_BANK));
  assign addr        = (ADDR_W'(row_in_bank) << ROW_SHIFT) | ADDR_W'(x);

endmodule

// File: rtl/cursor_painter.sv
// Cursor renderer: accumulates PS/2 deltas, restores/saves/paints the pixel under the cursor.
// Build option: define CURSOR_WRAP_EN to wrap the position instead of clamping it.
module cursor_painter
  import cursor_pkg::*;
#(
  parameter int                H_RES        = 64,
  parameter int                V_RES        = 64,
  parameter int                BANKS        = 2,
  parameter int                DATA_W       = 12,
  parameter int                ADDR_W       = 12,
  parameter int                RD_LAT       = 1,
  parameter logic [DATA_W-1:0] CURSOR_COLOR = DATA_W'(CURSOR_COLOR_DEF),
  parameter logic [DATA_W-1:0] DRAW_COLOR   = DATA_W'(DRAW_COLOR_DEF)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    packet_ready,
  input  logic [8:0]              ps2_dx,
  input  logic [8:0]              ps2_dy,
  input  logic [2:0]              ps2_btn,
  input  logic [BANKS*DATA_W-1:0] rdata,
  output logic [BANKS-1:0]        rd,
  output logic [BANKS-1:0]        wr,
  output logic [ADDR_W-1:0]       address,
  output logic [DATA_W-1:0]       wdata,
  output logic                    busy,
  output logic [7:0]              cursor_x,
  output logic [7:0]              cursor_y
);

  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int WAIT_W = 2;

  function automatic logic signed [10:0] sat_add(input logic signed [10:0] acc,
                                                 input logic signed [8:0]  d);
    logic signed [11:0] s;
    s = {acc[10], acc} + {{3{d[8]}}, d};
    if (s > 12'sd1023)  return 11'sd1023;
    if (s < -12'sd1023) return -11'sd1023;
    return s[10:0];
  endfunction

  function automatic logic [7:0] fit_pos(input logic signed [11:0] v, input int lim);
`ifdef CURSOR_WRAP_EN
    int r;
    r = int'(v) % lim;
    if (r < 0) r = r + lim;
    return 8'(r);
`else
    if (v < 12'sd0)         return 8'd0;
    if (int'(v) > lim - 1)  return 8'(lim - 1);
    return v[7:0];
`endif
  endfunction

  state_t                   state_q, state_d;
  logic signed [10:0]       pend_dx_q, pend_dx_d, pend_dy_q, pend_dy_d;
  logic                     pkt_q, pkt_d;
  logic [2:0]               btn_q, btn_d, btn_used_q, btn_used_d;
  logic [7:0]               cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
  logic [BANK_W-1:0]        old_bank_q, old_bank_d;
  logic [ADDR_W-1:0]        old_addr_q, old_addr_d;
  logic [DATA_W-1:0]        saved_q, saved_d;
  logic                     saved_valid_q, saved_valid_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic [BANKS-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0]        address_q, address_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;

  logic signed [11:0]       x_sum, y_sum;
  logic [7:0]               x_new, y_new, pos_x_sel, pos_y_sel;
  logic [BANK_W-1:0]        new_bank;
  logic [ADDR_W-1:0]        new_addr;

  assign x_sum = $signed({4'b0, cursor_x_q}) + $signed({pend_dx_q[10], pend_dx_q});
  assign y_sum = $signed({4'b0, cursor_y_q}) - $signed({pend_dy_q[10], pend_dy_q});
  assign x_new = fit_pos(x_sum, H_RES);
  assign y_new = fit_pos(y_sum, V_RES);

  // During UPDATE the position is not committed yet, so map the candidate directly.
  assign pos_x_sel = (state_q == ST_UPDATE) ? x_new : cursor_x_q;
  assign pos_y_sel = (state_q == ST_UPDATE) ? y_new : cursor_y_q;

  cursor_addr_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .BANKS (BANKS),
    .ADDR_W(ADDR_W),
    .BANK_W(BANK_W)
  ) u_addr_gen (
    .x   (pos_x_sel),
    .y   (pos_y_sel),
    .bank(new_bank),
    .addr(new_addr)
  );

  always_comb begin
    state_d       = state_q;
    pend_dx_d     = pend_dx_q;
    pend_dy_d     = pend_dy_q;
    pkt_d         = pkt_q;
    btn_d         = packet_ready ? ps2_btn : btn_q;
    btn_used_d    = btn_used_q;
    cursor_x_d    = cursor_x_q;
    cursor_y_d    = cursor_y_q;
    old_bank_d    = old_bank_q;
    old_addr_d    = old_addr_q;
    saved_d       = saved_q;
    saved_valid_d = saved_valid_q;
    wait_d        = wait_q;
    rd_d          = '0;
    wr_d          = '0;
    address_d     = address_q;
    wdata_d       = wdata_q;

    if (state_q == ST_UPDATE) begin
      pend_dx_d = packet_ready ? sat_add(11'sd0, $signed(ps2_dx)) : 11'sd0;
      pend_dy_d = packet_ready ? sat_add(11'sd0, $signed(ps2_dy)) : 11'sd0;
      pkt_d     = packet_ready;
    end else if (packet_ready) begin
      pend_dx_d = sat_add(pend_dx_q, $signed(ps2_dx));
      pend_dy_d = sat_add(pend_dy_q, $signed(ps2_dy));
      pkt_d     = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (pkt_q || packet_ready || (pend_dx_q != 11'sd0) || (pend_dy_q != 11'sd0))
          state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        cursor_x_d = x_new;
        cursor_y_d = y_new;
        btn_used_d = btn_q;
        if ((x_new == cursor_x_q) && (y_new == cursor_y_q) && (btn_q == btn_used_q))
          state_d = ST_IDLE;
        else if (saved_valid_q)
          state_d = ST_RESTORE;
        else
          state_d = ST_READ;
      end
      ST_RESTORE: state_d = ST_READ;
      ST_READ: begin
        if (RD_LAT > 1) begin
          state_d = ST_WAIT;
          wait_d  = WAIT_W'(RD_LAT - 2);
        end else begin
          state_d = ST_SAVE;
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) state_d = ST_SAVE;
        else              wait_d  = wait_q - 1'b1;
      end
      ST_SAVE: begin
        saved_d       = rdata[new_bank*DATA_W +: DATA_W];
        saved_valid_d = 1'b1;
        state_d       = ST_PAINT;
      end
      ST_PAINT: begin
        old_bank_d = new_bank;
        old_addr_d = new_addr;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the state being entered so they appear registered.
    case (state_d)
      ST_RESTORE: begin
        wr_d[old_bank_q] = 1'b1;
        address_d        = old_addr_q;
        if (btn_q[BTN_LEFT])       wdata_d = DRAW_COLOR;
        else if (btn_q[BTN_RIGHT]) wdata_d = '0;
        else                       wdata_d = saved_q;
      end
      ST_READ: begin
        rd_d[new_bank] = 1'b1;
        address_d      = new_addr;
      end
      ST_PAINT: begin
        wr_d[new_bank] = 1'b1;
        address_d      = new_addr;
        wdata_d        = CURSOR_COLOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pend_dx_q     <= '0;
      pend_dy_q     <= '0;
      pkt_q         <= 1'b0;
      btn_q         <= '0;
      btn_used_q    <= '0;
      cursor_x_q    <= '0;
      cursor_y_q    <= '0;
      old_bank_q    <= '0;
      old_addr_q    <= '0;
      saved_q       <= '0;
      saved_valid_q <= 1'b0;
      wait_q        <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
      address_q     <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      pend_dx_q     <= pend_dx_d;
      pend_dy_q     <= pend_dy_d;
      pkt_q         <= pkt_d;
      btn_q         <= btn_d;
      btn_used_q    <= btn_used_d;
      cursor_x_q    <= cursor_x_d;
      cursor_y_q    <= cursor_y_d;
      old_bank_q    <= old_bank_d;
      old_addr_q    <= old_addr_d;
      saved_q       <= saved_d;
      saved_valid_q <= saved_valid_d;
      wait_q        <= wait_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      address_q     <= address_d;
      wdata_q       <= wdata_d;
    end
  end

  assign rd       = rd_q;
  assign wr       = wr_q;
  assign address  = address_q;
  assign wdata    = wdata_q;
  assign busy     = (state_q != ST_IDLE);
  assign cursor_x = cursor_x_q;
  assign cursor_y = cursor_y_q;

endmodule

// File: tb/tb_cursor_painter.sv
// Directed table-driven bench for cursor_painter with a small RAM read-latency model.
module tb_cursor_painter;

  localparam int BANKS  = 2;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 12;
  localparam int RD_LAT = 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    packet_ready;
  logic [8:0]              ps2_dx, ps2_dy;
  logic [2:0]              ps2_btn;
  logic [BANKS*DATA_W-1:0] rdata;
  logic [BANKS-1:0]        rd, wr;
  logic [ADDR_W-1:0]       address;
  logic [DATA_W-1:0]       wdata;
  logic                    busy;
  logic [7:0]              cursor_x, cursor_y;

  always #5 clk = ~clk;

  cursor_painter #(
    .BANKS (BANKS),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .packet_ready(packet_ready),
    .ps2_dx      (ps2_dx),
    .ps2_dy      (ps2_dy),
    .ps2_btn     (ps2_btn),
    .rdata       (rdata),
    .rd          (rd),
    .wr          (wr),
    .address     (address),
    .wdata       (wdata),
    .busy        (busy),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y)
  );

  // RAM model: the pixel under the cursor appears on the read bank RD_LAT cycles after rd.
  logic [DATA_W-1:0] cur_under = '0;
  logic [BANKS-1:0]  rd_pipe [RD_LAT];

  always @(posedge clk) begin
    rd_pipe[0] <= rd;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  always_comb begin
    rdata = {BANKS{12'hBAD}};
    for (int b = 0; b < BANKS; b++)
      if (rd_pipe[RD_LAT-1][b]) rdata[b*DATA_W +: DATA_W] = cur_under;
  end

  typedef struct {
    int dx, dy, btn, under;
    int rs_en, rs_bank, rs_addr, rs_data;
    int nb, na, ex, ey;
  } vec_t;

  vec_t vt [9];
  int   n_cmp  = 0;
  int   n_miss = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [BANKS-1:0] v);
    int r = -1;
    for (int b = 0; b < BANKS; b++) if (v[b]) r = b;
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int wr_n = 0, rd_n = 0, fall = -1, multi = 0, rc = -1, rb = -1, ra = -1, skip, pi;
    int wc[4], wb[4], wa[4], wd[4];
    string t;
    for (int i = 0; i < 4; i++) begin wc[i] = -1; wb[i] = -1; wa[i] = -1; wd[i] = -1; end
    cur_under = DATA_W'(v.under);
    @(negedge clk);
    packet_ready = 1'b1; ps2_dx = 9'(v.dx); ps2_dy = 9'(v.dy); ps2_btn = 3'(v.btn);
    for (int c = 1; c <= 30 && fall < 0; c++) begin
      @(negedge clk);
      packet_ready = 1'b0;
      if ($countones({rd, wr}) > 1) multi++;
      if (wr != '0 && wr_n < 4) begin
        wc[wr_n] = c; wb[wr_n] = oh2i(wr); wa[wr_n] = int'(address); wd[wr_n] = int'(wdata);
        wr_n++;
      end
      if (rd != '0) begin
        if (rd_n == 0) begin rc = c; rb = oh2i(rd); ra = int'(address); end
        rd_n++;
      end
      if (!busy) fall = c;
    end
    t    = $sformatf("v%0d", id);
    skip = v.rs_en ? 0 : 1;
    chk({t, ".wr_count"}, wr_n, v.rs_en + 1);
    if (v.rs_en != 0) begin
      chk({t, ".restore_cyc"},  wc[0], 2);
      chk({t, ".restore_bank"}, wb[0], v.rs_bank);
      chk({t, ".restore_addr"}, wa[0], v.rs_addr);
      chk({t, ".restore_data"}, wd[0], v.rs_data);
    end
    chk({t, ".rd_count"}, rd_n, 1);
    chk({t, ".rd_cyc"},   rc, 3 - skip);
    chk({t, ".rd_bank"},  rb, v.nb);
    chk({t, ".rd_addr"},  ra, v.na);
    pi = (wr_n > 0) ? wr_n - 1 : 0;
    chk({t, ".paint_cyc"},  wc[pi], 4 + RD_LAT - skip);
    chk({t, ".paint_bank"}, wb[pi], v.nb);
    chk({t, ".paint_addr"}, wa[pi], v.na);
    chk({t, ".paint_data"}, wd[pi], 'h004);
    chk({t, ".busy_fall"},  fall, 5 + RD_LAT - skip);
    chk({t, ".cursor_x"},   int'(cursor_x), v.ex);
    chk({t, ".cursor_y"},   int'(cursor_y), v.ey);
    chk({t, ".one_strobe"}, multi, 0);
  endtask

  initial begin
    int paints, first_pa, last_pa, last_pb, strobes;
    int exp_pa1, exp_pa2, exp_pb, exp_x;

    //          dx    dy  btn under  rs bank addr   data    nb  na     x   y
    vt[0] = '{   5,   -3, 0, 'h0A0,  0, 0, 'h000, 'h000,  0, 'h0C5,  5,  3};
    vt[1] = '{   1,    0, 0, 'h123,  1, 0, 'h0C5, 'h0A0,  0, 'h0C6,  6,  3};
    vt[2] = '{  -1,  -28, 0, 'h0B0,  1, 0, 'h0C6, 'h123,  0, 'h7C5,  5, 31};
    vt[3] = '{   0,   -2, 0, 'h0C0,  1, 0, 'h7C5, 'h0B0,  1, 'h045,  5, 33};
`ifdef CURSOR_WRAP_EN
    vt[4] = '{-200,    0, 0, 'h0D0,  1, 1, 'h045, 'h0C0,  1, 'h07D, 61, 33};
    vt[5] = '{   1,    0, 1, 'h0E0,  1, 1, 'h07D, 'hFFF,  1, 'h07E, 62, 33};
    vt[6] = '{   1,    0, 2, 'h0F0,  1, 1, 'h07E, 'h000,  1, 'h07F, 63, 33};
    vt[7] = '{   1,    0, 0, 'h111,  1, 1, 'h07F, 'h0F0,  1, 'h040,  0, 33};
    vt[8] = '{   0,  100, 0, 'h222,  1, 1, 'h040, 'h111,  1, 'h740,  0, 61};
    exp_pa1 = 'h741; exp_pa2 = 'h744; exp_pb = 1; exp_x = 4;
`else
    vt[4] = '{-200,    0, 0, 'h0D0,  1, 1, 'h045, 'h0C0,  1, 'h040,  0, 33};
    vt[5] = '{   1,    0, 1, 'h0E0,  1, 1, 'h040, 'hFFF,  1, 'h041,  1, 33};
    vt[6] = '{   1,    0, 2, 'h0F0,  1, 1, 'h041, 'h000,  1, 'h042,  2, 33};
    vt[7] = '{   1,    0, 0, 'h111,  1, 1, 'h042, 'h0F0,  1, 'h043,  3, 33};
    vt[8] = '{   0,  100, 0, 'h222,  1, 1, 'h043, 'h111,  0, 'h003,  3,  0};
    exp_pa1 = 'h004; exp_pa2 = 'h007; exp_pb = 0; exp_x = 7;
`endif

    reset = 1'b1; packet_ready = 1'b0; ps2_dx = '0; ps2_dy = '0; ps2_btn = '0;
    repeat (3) @(negedge clk);
    chk("reset.strobes", int'({rd, wr}), 0);
    chk("reset.addr_data", int'({address, wdata}), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.cursor", int'({cursor_x, cursor_y}), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // Three packets during a move merge into one +3 move with no intermediate paint.
    cur_under = 12'h333;
    paints = 0; first_pa = -1; last_pa = -1; last_pb = -1;
    @(negedge clk);
    packet_ready = 1'b1; ps2_dx = 9'd1; ps2_dy = '0; ps2_btn = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      packet_ready = (c >= 2 && c <= 4);
      if (wr != '0 && wdata == 12'h004) begin
        paints++;
        if (first_pa < 0) first_pa = int'(address);
        last_pa = int'(address); last_pb = oh2i(wr);
      end
    end
    packet_ready = 1'b0;
    chk("merge.paints", paints, 2);
    chk("merge.first_addr", first_pa, exp_pa1);
    chk("merge.last_addr", last_pa, exp_pa2);
    chk("merge.last_bank", last_pb, exp_pb);
    chk("merge.cursor_x", int'(cursor_x), exp_x);
    chk("merge.idle", int'(busy), 0);

    // Reset during RESTORE aborts: strobes and position are gone the next cycle.
    @(negedge clk);
    packet_ready = 1'b1; ps2_dx = 9'd1;
    @(negedge clk);
    packet_ready = 1'b0;
    @(negedge clk);
    chk("abort.restore_seen", int'(wr != '0), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort.strobes", int'({rd, wr}), 0);
    chk("abort.busy", int'(busy), 0);
    chk("abort.cursor", int'({cursor_x, cursor_y}), 0);
    chk("abort.addr_data", int'({address, wdata}), 0);
    reset = 1'b0;

    // A null packet at an unchanged position only visits UPDATE.
    @(negedge clk);
    packet_ready = 1'b1; ps2_dx = '0; ps2_dy = '0; ps2_btn = '0;
    strobes = 0;
    @(negedge clk);
    packet_ready = 1'b0;
    chk("null.busy_n1", int'(busy), 1);
    strobes += $countones({rd, wr});
    @(negedge clk);
    chk("null.busy_n2", int'(busy), 0);
    for (int c = 0; c < 4; c++) begin
      strobes += $countones({rd, wr});
      @(negedge clk);
    end
    chk("null.strobes", strobes, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
